// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, symbol encoding and count limits.
// Also used by the translator lookup table.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_EMIT,
        ST_HOLD
    } state_t;

    localparam logic       MORSE_DOT    = 1'b0;
    localparam logic       MORSE_DASH   = 1'b1;
    localparam logic [2:0] MAX_SYMBOLS  = 3'd5;
    localparam logic [2:0] CNT_OVERFLOW = 3'd6;

    function automatic logic is_busy(input state_t s);
        return (s == ST_EMIT) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/morse_key_sync.sv
// Two-flop synchronizer for the raw key, plus one-cycle rise/fall pulses
// taken on the synchronized level.
module morse_key_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_key;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key front end: times presses and gaps, builds the symbol pattern,
// strobes trans at letter end and holds the pattern for the translator.
module morse_key_sequencer
    import morse_pkg::*;
#(
    parameter int MIN_PRESS_CYCLES = 2_000_000,
    parameter int DASH_CYCLES      = 30_000_000,
    parameter int GAP_CYCLES       = 80_000_000,
    parameter int HOLD_CYCLES      = 1_000_001,
    parameter int CNT_W            = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       clr,
    output logic [4:0] led_morse,
    output logic [2:0] led_cnt,
    output logic       trans,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] DASH_C    = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic w_rise;
    logic w_fall;

    morse_key_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_key  (key),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_morse;
    logic [2:0]       r_len;
    logic             r_trans;
    logic             r_busy;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [4:0]       w_morse_nx;
    logic [2:0]       w_len_nx;
    logic             w_dash;

    assign w_dash = (r_cnt >= DASH_C) ? MORSE_DASH : MORSE_DOT;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_morse_nx = r_morse;
        w_len_nx   = r_len;
        unique case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nx = ST_PRESS;
                    w_cnt_nx   = '0;
                end
            end
            ST_PRESS: begin
                if (r_cnt != '1)
                    w_cnt_nx = r_cnt + 1'b1;
                if (w_fall) begin
                    w_cnt_nx = '0;
                    if (r_cnt < MIN_C) begin
                        w_state_nx = (r_len == 3'd0) ? ST_IDLE : ST_GAP;
                    end else begin
                        w_state_nx = ST_GAP;
                        if (r_len < MAX_SYMBOLS) begin
                            w_morse_nx = {r_morse[3:0], w_dash};
                            w_len_nx   = r_len + 3'd1;
                        end else begin
                            w_len_nx   = CNT_OVERFLOW;
                        end
                    end
                end
            end
            ST_GAP: begin
                w_cnt_nx = r_cnt + 1'b1;
                // A new press beats a gap timeout on the same cycle
                if (w_rise) begin
                    w_state_nx = ST_PRESS;
                    w_cnt_nx   = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nx = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_state_nx = ST_HOLD;
                w_cnt_nx   = '0;
            end
            ST_HOLD: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == HOLD_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                    w_morse_nx = '0;
                    w_len_nx   = '0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        if (clr && !is_busy(r_state)) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_morse_nx = '0;
            w_len_nx   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_morse <= '0;
            r_len   <= '0;
            r_trans <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_morse <= w_morse_nx;
            r_len   <= w_len_nx;
            r_trans <= (w_state_nx == ST_EMIT);
            r_busy  <= is_busy(w_state_nx);
        end
    end

    assign led_morse = r_morse;
    assign led_cnt   = r_len;
    assign trans     = r_trans;
    assign busy      = r_busy;

endmodule
